// File: rtl/mailbox_controller_if.sv
// Data-bus responder handshake for the mailbox: request + stall.
interface mailbox_controller_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic [31:0] data_rd;
  logic        stall;

  modport master (
    output read, write, address, data_wr, mask,
    input  data_rd, stall
  );

  modport slave (
    input  read, write, address, data_wr, mask,
    output data_rd, stall
  );
endinterface

// File: rtl/mailbox_controller.sv
// Memory-mapped 32-bit FIFO mailbox with occupancy interrupt.
// Define MAILBOX_TIMESTAMP_EN to stamp each pushed entry with a cycle count.
module mailbox_controller #(
  parameter int DEPTH      = 16,
  parameter int IRQ_NUMBER = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mailbox_controller_if.slave  bus,
  output logic [7:0]           interrupt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic {S_IDLE, S_POP} state_e;
  state_e state_q, state_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   rd_reg_q;
  logic [7:0]    thresh_q;
  logic          irq_en_q, ovf_q, udf_q, irq_q;

  logic [2:0]  sel;
  logic        empty, full, push, do_push;
  logic        cap, do_pop, stall;
  logic        ctrl_wr, thr_wr, clr, fclr;
  logic [31:0] wdata, status, tstamp, rdata;
  logic [7:0]  thr_eff;
  logic        unused_addr;

  assign sel     = bus.address[4:2];
  assign empty   = count_q == '0;
  assign full    = count_q == FULL;
  assign push    = bus.write && sel == 3'd1;
  assign do_push = push && !full;
  assign ctrl_wr = bus.write && sel == 3'd2
                && bus.mask[0];
  assign thr_wr  = bus.write && sel == 3'd3
                && bus.mask[0];
  assign clr     = ctrl_wr && bus.data_wr[1];
  assign fclr    = ctrl_wr && bus.data_wr[2];
  assign thr_eff = (thresh_q == 8'd0) ? 8'd1
                 : thresh_q;
  assign unused_addr = ^{bus.address[31:5],
                         bus.address[1:0]};

  always_comb begin
    wdata = '0;
    for (int i = 0; i < 4; i++)
      wdata[8*i +: 8] = bus.mask[i]
                      ? bus.data_wr[8*i +: 8] : 8'h00;
  end

  // Head is captured on the stalled cycle, returned the next.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.read && sel == 3'd1) begin
          stall   = 1'b1;
          cap     = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign do_pop = cap && !empty;

  always_comb begin
    count_d = count_q;
    if (clr)          count_d = '0;
    else if (do_push) count_d = count_q + 1'b1;
    else if (do_pop)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_reg_q <= '0;
      thresh_q <= 8'd1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (cap)
        rd_reg_q <= empty ? '0 : mem_q[rd_ptr_q];
      if (ctrl_wr) irq_en_q <= bus.data_wr[0];
      if (thr_wr)  thresh_q <= bus.data_wr[7:0];
      if (fclr) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if (push && full) ovf_q <= 1'b1;
      if (cap && empty) udf_q <= 1'b1;
      irq_q <= irq_en_q
            && (32'(count_q) >= 32'(thr_eff));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

`ifdef MAILBOX_TIMESTAMP_EN
  logic [31:0] cyc_q, tstamp_q;
  logic [31:0] stamp_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (clr)
        tstamp_q <= '0;
      else if (cap)
        tstamp_q <= empty ? '0 : stamp_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) stamp_q[wr_ptr_q] <= cyc_q;
  end

  assign tstamp = tstamp_q;
`else
  assign tstamp = '0;
`endif

  assign status = {16'h0, 8'(count_q), 4'h0,
                   udf_q, ovf_q, !full, !empty};

  always_comb begin
    rdata = '0;
    if (state_q == S_POP) begin
      rdata = rd_reg_q;
    end else if (bus.read) begin
      unique case (sel)
        3'd0:    rdata = status;
        3'd2:    rdata = {31'h0, irq_en_q};
        3'd3:    rdata = {24'h0, thresh_q};
        3'd4:    rdata = tstamp;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.data_rd = rdata;
  assign bus.stall   = stall;

  always_comb begin
    interrupt             = '0;
    interrupt[IRQ_NUMBER] = irq_q;
  end
endmodule
